filter_ctrl: RTL and testbench
==============================

FILTER_CTRL -- requirements
Module: filter_ctrl

Interface
REQ-001 SHALL have parameter N, default 8, meaning pixel width in bits.
REQ-002 SHALL have parameter W, default 640, meaning pixels per line.
REQ-003 SHALL have parameter H, default 480, meaning lines per frame.
REQ-004 SHALL have parameter LAT, default 8, meaning filter core cycles from act pulse to valid result (LAT >= 1).
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port en  input  1  1 = filter mode, 0 = bypass mode; sampled only in IDLE.
REQ-008 SHALL have port in_valid  input  1  input pixel pair valid.
REQ-009 SHALL have port in_ready  output  1  controller accepts pair this cycle.
REQ-010 SHALL have port in_a  input  N  current-frame pixel.
REQ-011 SHALL have port in_b  input  N  reference pixel.
REQ-012 SHALL have port flt_act  output  1  one-cycle start pulse to filter core.
REQ-013 SHALL have port flt_a  output  N  operand a to core, held stable from act until capture.
REQ-014 SHALL have port flt_b  output  N  operand b to core, held stable from act until capture.
REQ-015 SHALL have port flt_result  input  2N  core result.
REQ-016 SHALL have port flt_ci  input  N  core auxiliary output c_i.
REQ-017 SHALL have port out_valid  output  1  output beat valid.
REQ-018 SHALL have port out_ready  input  1  downstream accepts beat.
REQ-019 SHALL have port out_data  output  2N  filtered result.
REQ-020 SHALL have port out_ci  output  N  captured c_i.
REQ-021 SHALL have port out_eol  output  1  beat is last pixel of a line.
REQ-022 SHALL have port out_eof  output  1  beat is last pixel of a frame.

Function
REQ-023 SHALL implement FSM states IDLE, ISSUE, WAIT, HOLD.
REQ-024 SHALL assert in_ready only in IDLE; transfer occurs when in_valid && in_ready.
REQ-025 On transfer with en=1: SHALL latch in_a/in_b into flt_a/flt_b and go to ISSUE.
REQ-026 ISSUE: SHALL drive flt_act=1 for exactly one cycle, load wait counter with LAT-1, go to WAIT.
REQ-027 WAIT: SHALL decrement counter each cycle; at 0 capture flt_result/flt_ci into out registers, go to HOLD.
REQ-028 On transfer with en=0: SHALL load out_data = {N'b0, in_a}, out_ci = 0, no flt_act, go directly to HOLD (1-cycle latency).
REQ-029 HOLD: SHALL assert out_valid; out_data/out_ci/out_eol/out_eof stable until out_ready=1, then go to IDLE.
REQ-030 Latency transfer->out_valid SHALL be LAT+2 cycles in filter mode, 1 cycle in bypass.
REQ-031 Throughput SHALL be at most one pixel per LAT+3 cycles; no overlapping core operations.
REQ-032 SHALL keep column counter 0..W-1 and row counter 0..H-1, advanced on each output handshake.
REQ-033 out_eol SHALL equal (col == W-1); out_eof SHALL equal (col == W-1 && row == H-1).
REQ-034 At col W-1 handshake: col wraps to 0, row increments; at row H-1 also wraps to 0.
REQ-035 en changes outside IDLE SHALL not affect the in-flight pixel.
REQ-036 in_valid while not IDLE SHALL be ignored (no transfer, no state change).

Reset
REQ-037 On rst_n=0 SHALL immediately enter IDLE and clear counters, flt_a, flt_b, out_data, out_ci, out_eol, out_eof, out_valid, flt_act to 0.
REQ-038 Reset during WAIT or HOLD SHALL discard the in-flight pixel; after release in_ready=1 next cycle.

Verification
REQ-039 Reset then en=1, in_a=255, in_b=50 -> one flt_act pulse at cycle 1; out_valid at cycle LAT+2 with out_data = flt_result captured at WAIT end.
REQ-040 en=0, in_a=30, in_b=70 -> out_valid next cycle, out_data=16'd30, out_ci=0, no flt_act.
REQ-041 out_ready held 0 for 5 cycles in HOLD -> out_data stable, in_ready=0 throughout, one beat on release.
REQ-042 W=4, H=2, stream 8 pixels -> out_eol on beats 4 and 8, out_eof only on beat 8, counters at 0 afterwards.
REQ-043 rst_n pulsed low mid-WAIT -> all outputs 0 asynchronously, no out_valid for that pixel, next pixel processed normally.

Source files
------------

// File: rtl/filter_ctrl.sv
// filter_ctrl: sequences one pixel pair at a time through a fixed-latency filter core (or bypasses it) and tags output beats with end-of-line/end-of-frame
module filter_ctrl #(
  parameter int N   = 8,
  parameter int W   = 640,
  parameter int H   = 480,
  parameter int LAT = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  output logic           flt_act,
  output logic [N-1:0]   flt_a,
  output logic [N-1:0]   flt_b,
  input  logic [2*N-1:0] flt_result,
  input  logic [N-1:0]   flt_ci,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_data,
  output logic [N-1:0]   out_ci,
  output logic           out_eol,
  output logic           out_eof
);
  localparam int CW = $clog2(LAT + 1);
  localparam int XW = $clog2(W + 1);
  localparam int YW = $clog2(H + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] col_q, col_d;
  logic [YW-1:0] row_q, row_d;
  logic [N-1:0] a_q, a_d, b_q, b_d, ci_q, ci_d;
  logic [2*N-1:0] data_q, data_d;
  logic hs, last_col, last_row;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    data_d   = data_q;
    ci_d     = ci_q;
    hs       = state_q == HOLD && out_ready;
    last_col = col_q == XW'(W - 1);
    last_row = row_q == YW'(H - 1);
    col_d    = hs ? (last_col ? '0 : col_q + 1'b1) : col_q;
    row_d    = hs && last_col ? (last_row ? '0 : row_q + 1'b1) : row_q;
    case (state_q)
      IDLE: begin
        if (in_valid && en) begin
          a_d     = in_a;
          b_d     = in_b;
          state_d = ISSUE;
        end else if (in_valid) begin
          data_d  = {{N{1'b0}}, in_a};
          ci_d    = '0;
          state_d = HOLD;
        end
      end
      ISSUE: begin
        cnt_d   = CW'(LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          data_d  = flt_result;
          ci_d    = flt_ci;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: state_d = out_ready ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      ci_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      ci_q    <= ci_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign flt_act   = state_q == ISSUE;
  assign out_valid = state_q == HOLD;
  assign flt_a     = a_q;
  assign flt_b     = b_q;
  assign out_data  = data_q;
  assign out_ci    = ci_q;
  assign out_eol   = out_valid && last_col;
  assign out_eof   = out_valid && last_col && last_row;
endmodule

// File: tb/tb_filter_ctrl.sv
// tb_filter_ctrl: directed self-checking bench for filter_ctrl with a fixed-latency core model
module tb_filter_ctrl;
  localparam int LAT = 3;
  logic clk, rst_n, en, in_valid, in_ready, flt_act, out_valid, out_ready, out_eol, out_eof;
  logic [7:0] in_a, in_b, flt_a, flt_b, flt_ci, out_ci;
  logic [15:0] flt_result, out_data;
  int total, fails, acts, cyc, act_cyc, n;
  bit seen;
  filter_ctrl #(.N(8), .W(4), .H(2), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .flt_act(flt_act), .flt_a(flt_a), .flt_b(flt_b),
    .flt_result(flt_result), .flt_ci(flt_ci), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ci(out_ci), .out_eol(out_eol), .out_eof(out_eof)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    cyc     = 0;
    act_cyc = -100;
    acts    = 0;
  end
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (flt_act === 1'b1) begin
      act_cyc <= cyc;
      acts    <= acts + 1;
    end
  end
  assign flt_result = (cyc == act_cyc + LAT) ? 16'(flt_a * flt_b) : 16'hDEAD;
  assign flt_ci     = (cyc == act_cyc + LAT) ? (flt_a ^ flt_b) : 8'hEE;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic pixel(input bit e, input logic [7:0] a, input logic [7:0] b, input logic [15:0] d_exp,
                       input logic [7:0] c_exp, input bit eol_exp, input bit eof_exp);
    en = e; in_a = a; in_b = b; in_valid = 1'b1;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    chk("act_cycle1", 32'(flt_act), 32'(e));
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), e ? 32'(LAT + 2) : 32'd1);
    chk("out_data", 32'(out_data), 32'(d_exp));
    chk("out_ci", 32'(out_ci), 32'(c_exp));
    chk("out_eol", 32'(out_eol), 32'(eol_exp));
    chk("out_eof", 32'(out_eof), 32'(eof_exp));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", 32'(out_valid), 32'd0);
  endtask
  initial begin
    total = 0; fails = 0;
    rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_flt_act", 32'(flt_act), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_flt_a", 32'(flt_a), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    pixel(1'b1, 8'd255, 8'd50, 16'd12750, 8'hCD, 1'b0, 1'b0);
    chk("acts_filter", 32'(acts), 32'd1);
    pixel(1'b0, 8'd30, 8'd70, 16'd30, 8'd0, 1'b0, 1'b0);
    chk("acts_bypass", 32'(acts), 32'd1);
    en = 1'b1; in_a = 8'd10; in_b = 8'd20; in_valid = 1'b1;
    @(negedge clk);
    en = 1'b0; in_a = 8'd99;
    n = 1;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_latency", 32'(n), 32'(LAT + 2));
    for (int i = 0; i < 5; i++) begin
      chk("stall_data", 32'(out_data), 32'd200);
      chk("stall_ci", 32'(out_ci), 32'd30);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    chk("stall_acts", 32'(acts), 32'd2);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("stall_one_beat", 32'(out_valid), 32'd0);
    en = 1'b1; in_a = 8'd7; in_b = 8'd9; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
    chk("arst_flt_a", 32'(flt_a), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    chk("discarded", 32'(seen), 32'd0);
    for (int i = 0; i < 9; i++) begin
      pixel(i[0], 8'(i + 1), 8'(i + 3),
            i[0] ? 16'((i + 1) * (i + 3)) : 16'(i + 1),
            i[0] ? 8'((i + 1) ^ (i + 3)) : 8'd0,
            (i % 4) == 3, i == 7);
    end
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
